datapath_ctrl: RTL and testbench



---
 rtl/dp_ctrl_pkg.sv | 59 +++++
 rtl/datapath_ctrl_instr_fifo.sv | 53 +++++
 rtl/datapath_ctrl.sv | 112 +++++++++++
 tb/tb_datapath_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/dp_ctrl_pkg.sv
// Shared encodings for the datapath control-word generator: CW bit layout,
// instruction classes, SYS opcodes, FSM states and the instruction record.
package dp_ctrl_pkg;

  localparam int CW_W     = 13;
  localparam int CW_DA_HI = 12;
  localparam int CW_DA_LO = 11;
  localparam int CW_AA_HI = 10;
  localparam int CW_AA_LO = 9;
  localparam int CW_BA_HI = 8;
  localparam int CW_BA_LO = 7;
  localparam int CW_MB    = 6;
  localparam int CW_FS_HI = 5;
  localparam int CW_FS_LO = 2;
  localparam int CW_MD    = 1;
  localparam int CW_WR    = 0;

  localparam logic [1:0] CLS_SYS  = 2'b00;
  localparam logic [1:0] CLS_LD   = 2'b01;
  localparam logic [1:0] CLS_ALU  = 2'b10;
  localparam logic [1:0] CLS_ALUI = 2'b11;

  localparam logic [3:0] SYS_NOP  = 4'b0000;
  localparam logic [3:0] SYS_HALT = 4'b0001;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  typedef struct packed {
    logic [1:0] cls;
    logic [1:0] dst;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] fs;
    logic [3:0] imm;
  } instr_t;

  function automatic logic [CW_W-1:0] build_cw(
    input logic [1:0] da,
    input logic [1:0] aa,
    input logic [1:0] ba,
    input logic       mb,
    input logic [3:0] fs,
    input logic       md,
    input logic       wr
  );
    logic [CW_W-1:0] cw;
    cw                    = {CW_W{1'b0}};
    cw[CW_DA_HI:CW_DA_LO] = da;
    cw[CW_AA_HI:CW_AA_LO] = aa;
    cw[CW_BA_HI:CW_BA_LO] = ba;
    cw[CW_MB]             = mb;
    cw[CW_FS_HI:CW_FS_LO] = fs;
    cw[CW_MD]             = md;
    cw[CW_WR]             = wr;
    return cw;
  endfunction

endpackage

// File: rtl/datapath_ctrl_instr_fifo.sv
// Instruction FIFO with wrap-bit pointers; refuses pushes when full and pops when empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_q[AW-1:0]];

  // Next pointer values
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + (AW+1)'(1);
    else         wr_d = wr_q;
    if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
    else         rd_d = rd_q;
  end

  // Pointer registers; reset flushes the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: entries are only read between the pointers
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Control-word generator: buffers instructions, decodes one per cycle into a
// registered CW/CONSTANT/DATA for the register-file datapath, with HALT/GO stepping.
module datapath_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  output logic             in_ready,
  input  logic             go,
  output logic [12:0]      CW,
  output logic [3:0]       CONSTANT,
  output logic [3:0]       DATA,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] issued_cnt
);
  logic [0:0]       state_q, state_d;
  logic [12:0]      cw_q, cw_d;
  logic [3:0]       const_q, const_d;
  logic [3:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_s, empty_s, pop_s;
  logic [15:0]      head_raw_s;
  instr_t           head_s;

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (in_valid),
    .pop   (pop_s),
    .din   (in_instr),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_raw_s)
  );

  assign head_s = instr_t'(head_raw_s);

  // Decode and issue FSM; CONSTANT/DATA keep their last value unless reloaded
  always_comb begin
    state_d = state_q;
    cw_d    = 13'b0;
    const_d = const_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!empty_s) begin
          pop_s = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          case (head_s.cls)
            CLS_SYS: begin
              if (head_s.imm == SYS_HALT) state_d = ST_HALTED;
              else                        state_d = ST_RUN;
            end
            CLS_LD: begin
              cw_d   = build_cw(head_s.dst, 2'b00, 2'b00, 1'b0, 4'b0000, 1'b1, 1'b1);
              data_d = head_s.imm;
            end
            CLS_ALU: begin
              cw_d = build_cw(head_s.dst, head_s.src_a, head_s.src_b, 1'b0, head_s.fs, 1'b0, 1'b1);
            end
            CLS_ALUI: begin
              cw_d    = build_cw(head_s.dst, head_s.src_a, 2'b00, 1'b1, head_s.fs, 1'b0, 1'b1);
              const_d = head_s.imm;
            end
            default: cw_d = 13'b0;
          endcase
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_HALTED: begin
        if (go) state_d = ST_RUN;
        else    state_d = ST_HALTED;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Registered control outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      cw_q    <= 13'b0;
      const_q <= 4'b0;
      data_q  <= 4'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      const_q <= const_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready   = !full_s;
  assign CW         = cw_q;
  assign CONSTANT   = const_q;
  assign DATA       = data_q;
  assign busy       = !empty_s || cw_q[CW_WR];
  assign halted     = (state_q == ST_HALTED);
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed self-checking bench for datapath_ctrl (DEPTH=4, CNT_W=3).
module tb_datapath_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = 16'h0000;
  logic        go = 1'b0;
  logic        in_ready, busy, halted;
  logic [12:0] CW;
  logic [3:0]  CONSTANT, DATA;
  logic [2:0]  issued_cnt;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_cnt = 3'd0;

  datapath_ctrl #(.DEPTH(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .go(go), .CW(CW), .CONSTANT(CONSTANT), .DATA(DATA),
    .busy(busy), .halted(halted), .issued_cnt(issued_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [1:0] cls, input logic [1:0] dst,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [3:0] fs, input logic [3:0] imm);
    return {cls, dst, sa, sb, fs, imm};
  endfunction

  task automatic test_reset();
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    checks++; if (CW !== 13'b0) begin errors++; $display("FAIL reset_cw got=%b exp=%b", CW, 13'b0); end
    checks++; if (CONSTANT !== 4'd0 || DATA !== 4'd0) begin errors++; $display("FAIL reset_imm got=%h/%h exp=0/0", CONSTANT, DATA); end
    checks++; if (issued_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", issued_cnt); end
    checks++; if ({in_ready, busy, halted} !== 3'b100) begin errors++; $display("FAIL reset_status got=%b exp=100", {in_ready, busy, halted}); end
    exp_cnt = 3'd0;
  endtask

  task automatic test_load();
    logic [15:0] ins [4];
    logic [12:0] ecw [4];
    logic [3:0]  edat [4];
    ins[0] = mk(2'b01, 2'd0, 2'd0, 2'd0, 4'd0, 4'b0101); ecw[0] = 13'b0000000000011; edat[0] = 4'd5;
    ins[1] = mk(2'b01, 2'd1, 2'd0, 2'd0, 4'd0, 4'b0101); ecw[1] = 13'b0100000000011; edat[1] = 4'd5;
    ins[2] = mk(2'b01, 2'd2, 2'd0, 2'd0, 4'd0, 4'b0110); ecw[2] = 13'b1000000000011; edat[2] = 4'd6;
    ins[3] = mk(2'b01, 2'd3, 2'd0, 2'd0, 4'd0, 4'b0111); ecw[3] = 13'b1100000000011; edat[3] = 4'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) in_instr = ins[i];
      else       in_valid = 1'b0;
      tick();
      if (i == 0) begin
        checks++; if (CW !== 13'b0) begin errors++; $display("FAIL load_latency got=%b exp=%b", CW, 13'b0); end
      end else begin
        checks++; if (CW !== ecw[i-1] || DATA !== edat[i-1]) begin errors++; $display("FAIL load_cw%0d got=%b/%h exp=%b/%h", i-1, CW, DATA, ecw[i-1], edat[i-1]); end
      end
    end
    exp_cnt = exp_cnt + 3'd4;
    checks++; if (issued_cnt !== exp_cnt) begin errors++; $display("FAIL load_cnt got=%0d exp=%0d", issued_cnt, exp_cnt); end
  endtask

  task automatic test_alu_reg();
    in_valid = 1'b1;
    in_instr = mk(2'b10, 2'd3, 2'd0, 2'd1, 4'b0001, 4'd0); tick();
    checks++; if (CW !== 13'b0) begin errors++; $display("FAIL alu_idle_cw got=%b exp=0", CW); end
    in_instr = mk(2'b10, 2'd2, 2'd3, 2'd1, 4'b1010, 4'd0); tick();
    checks++; if (CW !== 13'b1100010000101) begin errors++; $display("FAIL alu_add_cw got=%b exp=1100010000101", CW); end
    in_valid = 1'b0; tick();
    checks++; if (CW !== 13'b1011010101001) begin errors++; $display("FAIL alu_sub_cw got=%b exp=1011010101001", CW); end
    tick();
    checks++; if (CW !== 13'b0 || busy !== 1'b0) begin errors++; $display("FAIL alu_drain got=%b busy=%b exp=0 busy=0", CW, busy); end
    exp_cnt = exp_cnt + 3'd2;
    checks++; if (issued_cnt !== exp_cnt) begin errors++; $display("FAIL alu_cnt got=%0d exp=%0d", issued_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins [4];
    logic [12:0] ecw [4];
    for (int i = 0; i < 4; i++) begin
      ins[i] = mk(2'b11, 2'(i), 2'(i + 1), 2'd2, 4'b0001, 4'(9 + i));
      ecw[i] = {2'(i), 2'(i + 1), 2'b00, 1'b1, 4'b0001, 1'b0, 1'b1};
    end
    in_valid = 1'b1;
    in_instr = mk(2'b00, 2'd0, 2'd0, 2'd0, 4'd0, 4'b0001); tick();
    for (int i = 0; i < 4; i++) begin
      in_instr = ins[i]; tick();
      if (i == 0) begin
        checks++; if (halted !== 1'b1 || CW !== 13'b0) begin errors++; $display("FAIL halt_enter halted=%b cw=%b exp=1/0", halted, CW); end
        exp_cnt = exp_cnt + 3'd1;
      end
    end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_full ready=%b busy=%b exp=0/1", in_ready, busy); end
    in_instr = mk(2'b11, 2'd0, 2'd0, 2'd0, 4'b1111, 4'd15); tick(); tick();
    checks++; if (in_ready !== 1'b0 || CW !== 13'b0 || halted !== 1'b1) begin errors++; $display("FAIL bp_hold ready=%b cw=%b halted=%b exp=0/0/1", in_ready, CW, halted); end
    checks++; if (issued_cnt !== exp_cnt) begin errors++; $display("FAIL halt_cnt got=%0d exp=%0d", issued_cnt, exp_cnt); end
    in_valid = 1'b0;
    go = 1'b1; tick(); go = 1'b0;
    checks++; if (halted !== 1'b0 || CW !== 13'b0) begin errors++; $display("FAIL go_resume halted=%b cw=%b exp=0/0", halted, CW); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (CW !== ecw[i] || CONSTANT !== 4'(9 + i) || in_ready !== 1'b1) begin errors++; $display("FAIL alui_cw%0d got=%b/%h rdy=%b exp=%b/%h rdy=1", i, CW, CONSTANT, in_ready, ecw[i], 4'(9 + i)); end
    end
    tick();
    checks++; if (CW !== 13'b0 || busy !== 1'b0 || CONSTANT !== 4'd12) begin errors++; $display("FAIL bp_noextra cw=%b busy=%b const=%h exp=0/0/c", CW, busy, CONSTANT); end
    exp_cnt = exp_cnt + 3'd4;
  endtask

  task automatic test_idle();
    go = 1'b1; tick(); go = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (CW !== 13'b0 || busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL idle cw=%b busy=%b halted=%b exp=0/0/0", CW, busy, halted); end
    checks++; if (issued_cnt !== exp_cnt) begin errors++; $display("FAIL idle_cnt got=%0d exp=%0d", issued_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_instr = mk(2'b00, 2'd0, 2'd0, 2'd0, 4'd0, 4'b0001); tick();
    for (int i = 0; i < 4; i++) begin
      in_instr = mk(2'b01, 2'(i), 2'd0, 2'd0, 4'd0, 4'(i + 1)); tick();
    end
    RST = 1'b1; in_instr = mk(2'b01, 2'd0, 2'd0, 2'd0, 4'd0, 4'd8); tick();
    RST = 1'b0; in_valid = 1'b0;
    exp_cnt = 3'd0;
    checks++; if (CW !== 13'b0 || busy !== 1'b0 || in_ready !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL rst_mid cw=%b busy=%b rdy=%b halted=%b exp=0/0/1/0", CW, busy, in_ready, halted); end
    checks++; if (issued_cnt !== 3'd0 || DATA !== 4'd0) begin errors++; $display("FAIL rst_mid_cnt cnt=%0d data=%h exp=0/0", issued_cnt, DATA); end
    tick(); tick(); tick();
    checks++; if (CW !== 13'b0 || issued_cnt !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_flushed cw=%b cnt=%0d busy=%b exp=0/0/0", CW, issued_cnt, busy); end
  endtask

  task automatic test_wrap();
    int cw_bad;
    cw_bad = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) in_instr = mk(2'b00, 2'd3, 2'd2, 2'd1, 4'hf, (i == 4) ? 4'b0101 : 4'b0000);
      else       in_valid = 1'b0;
      tick();
      if (CW !== 13'b0) cw_bad++;
    end
    exp_cnt = exp_cnt + 3'd1;
    checks++; if (cw_bad !== 0) begin errors++; $display("FAIL wrap_cw nonzero_cycles=%0d exp=0", cw_bad); end
    checks++; if (issued_cnt !== exp_cnt || exp_cnt !== 3'd1) begin errors++; $display("FAIL wrap_cnt got=%0d exp=1", issued_cnt); end
    checks++; if (halted !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wrap_status halted=%b busy=%b exp=0/0", halted, busy); end
  endtask

  initial begin
    #2;
    test_reset();
    test_load();
    test_alu_reg();
    test_back_to_back();
    test_idle();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
